// File: rtl/if_id_fetch_queue.sv
// IF -> ID decoupling buffer: small circular FIFO of {PC+4, instruction} pairs
// feeding a registered IF/ID output stage, with back-pressure, stall and flush.
module if_id_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instruction,
    output logic             if_freeze,
    input  logic             flush,
    input  logic             hazard_freeze,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instruction,
    output logic [PTR_W:0]   level
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    entry_t           mem [DEPTH];
    entry_t           rdEnt;
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [PTR_W:0]   count;
    logic             accept, advance, wrEn;

    // Freeze comes from registered occupancy only, keeping IF's PC path short.
    assign if_freeze = (count == FULL_CNT);
    assign accept    = in_valid & ~if_freeze & ~flush;
    assign advance   = ~hazard_freeze;
    assign level     = count;
    assign rdEnt     = mem[rdPtr];

    // Bypass (empty queue, no stall) skips the storage entirely.
    assign wrEn = rst & accept & (hazard_freeze | (count != '0));

    always_ff @(posedge clk) begin
        if (wrEn)
            mem[wrPtr] <= entry_t'{pc: in_pc, instr: in_instruction};
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wrPtr           <= '0;
            rdPtr           <= '0;
            count           <= '0;
            out_valid       <= 1'b0;
            out_pc          <= '0;
            out_instruction <= '0;
        end else if (advance) begin
            if (count != '0) begin
                out_valid       <= 1'b1;
                out_pc          <= rdEnt.pc;
                out_instruction <= rdEnt.instr;
                rdPtr           <= rdPtr + PTR_W'(1);
                if (accept)
                    wrPtr <= wrPtr + PTR_W'(1);
                else
                    count <= count - (PTR_W+1)'(1);
            end else if (accept) begin
                out_valid       <= 1'b1;
                out_pc          <= in_pc;
                out_instruction <= in_instruction;
            end else begin
                out_valid       <= 1'b0;
                out_pc          <= '0;
                out_instruction <= '0;
            end
        end else if (accept) begin
            wrPtr <= wrPtr + PTR_W'(1);
            count <= count + (PTR_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Scoreboard bench for if_id_fetch_queue: a behavioural IF feeds the queue,
// accepted words are queued as expectations and popped as ID loads them.
module tb_if_id_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [31:0]      in_pc;
    logic [31:0]      in_instruction;
    logic             if_freeze;
    logic             flush;
    logic             hazard_freeze;
    logic             out_valid;
    logic [31:0]      out_pc;
    logic [31:0]      out_instruction;
    logic [PTR_W:0]   level;

    if_id_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc),
        .in_instruction(in_instruction), .if_freeze(if_freeze), .flush(flush),
        .hazard_freeze(hazard_freeze), .out_valid(out_valid), .out_pc(out_pc),
        .out_instruction(out_instruction), .level(level)
    );

    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [63:0] sbq [$];
    logic [31:0] pc = 32'd4;
    logic        lastV = 1'b0;
    logic [31:0] lastPc = '0, lastIns = '0;

    function automatic logic [31:0] mkInstr(input logic [31:0] p);
        return (p * 32'h0101_0101) ^ 32'hE3A0_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, account acceptance at the edge, check at next negedge.
    task automatic tick(input logic hf, input logic fl, input logic iv, input logic rs);
        logic        acc;
        logic [63:0] e;
        hazard_freeze  = hf;
        flush          = fl;
        in_valid       = iv;
        rst            = rs;
        in_pc          = pc;
        in_instruction = mkInstr(pc);
        acc = iv && !if_freeze && !fl && rs;
        @(posedge clk);
        if (!rs || fl) begin
            sbq.delete();
            if (rs) pc = 32'h48;
        end else if (acc) begin
            sbq.push_back({pc, mkInstr(pc)});
            pc += 32'd4;
        end
        @(negedge clk);
        if (!rs || fl) begin
            chk("clr_valid", {31'b0, out_valid}, 32'd0);
            chk("clr_pc",    out_pc,             32'd0);
            chk("clr_instr", out_instruction,    32'd0);
            lastV = 1'b0; lastPc = '0; lastIns = '0;
        end else if (!hf) begin
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("pop_valid", {31'b0, out_valid}, 32'd1);
                chk("pop_pc",    out_pc,             e[63:32]);
                chk("pop_instr", out_instruction,    e[31:0]);
                lastV = 1'b1; lastPc = e[63:32]; lastIns = e[31:0];
            end else begin
                chk("bub_valid", {31'b0, out_valid}, 32'd0);
                chk("bub_pc",    out_pc,             32'd0);
                chk("bub_instr", out_instruction,    32'd0);
                lastV = 1'b0; lastPc = '0; lastIns = '0;
            end
        end else begin
            chk("hold_valid", {31'b0, out_valid}, {31'b0, lastV});
            chk("hold_pc",    out_pc,             lastPc);
            chk("hold_instr", out_instruction,    lastIns);
        end
        chk("level",  32'(level), 32'(sbq.size()));
        chk("freeze", {31'b0, if_freeze}, (sbq.size() == DEPTH) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; hazard_freeze = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_instruction = '0;
        @(negedge clk);

        // reset
        repeat (2) tick(0, 0, 1, 0);
        chk("rst_level", 32'(level), 32'd0);

        // free run: one-cycle latency, queue stays empty
        tick(0, 0, 1, 1);
        chk("first_pc", out_pc, 32'd4);
        repeat (7) tick(0, 0, 1, 1);
        chk("run_level", 32'(level), 32'd0);

        // stall fill
        for (int i = 1; i <= 6; i++) begin
            tick(1, 0, 1, 1);
            chk("fill_level", 32'(level), (i < 4) ? 32'(i) : 32'd4);
        end
        chk("fill_freeze", {31'b0, if_freeze}, 32'd1);

        // full + single pop, then push+pop
        tick(0, 0, 1, 1);
        chk("pop1_level", 32'(level), 32'd3);
        chk("pop1_freeze", {31'b0, if_freeze}, 32'd0);
        tick(0, 0, 1, 1);
        chk("pp_level", 32'(level), 32'd3);

        // flush with stall at level 3, branch target via bypass
        tick(1, 1, 1, 1);
        tick(0, 0, 1, 1);
        chk("tgt_pc", out_pc, 32'h48);
        chk("tgt_valid", {31'b0, out_valid}, 32'd1);

        // fill, glitch rst between edges (no effect), then real reset
        repeat (5) tick(1, 0, 1, 1);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("glitch_level", 32'(level), 32'd4);
        chk("glitch_valid", {31'b0, out_valid}, 32'd1);
        tick(1, 0, 1, 0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_freeze", {31'b0, if_freeze}, 32'd0);

        // bubbles then resume
        repeat (2) tick(0, 0, 0, 1);
        repeat (4) tick(0, 0, 1, 1);

        // random traffic
        for (int i = 0; i < 300; i++)
            tick($urandom_range(99) < 35, $urandom_range(99) < 3,
                 $urandom_range(99) < 90, 1'b1);

        // drain
        repeat (DEPTH + 2) tick(0, 0, 0, 1);
        chk("drained", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
